mem_wb_writeback: RTL



---
 rtl/mips8_pkg.sv | 17 +
 rtl/wb_result_mux.sv | 11 +
 rtl/mem_wb_writeback.sv | 78 +++++++
 3 files changed

// File: rtl/mips8_pkg.sv
// rtl/mips8_pkg.sv - shared widths, writeback state and entry types for the 8-bit MIPS core
package mips8_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_result_mux.sv
// rtl/wb_result_mux.sv - selects load data or ALU result as the writeback value
module wb_result_mux
    import mips8_pkg::*;
(
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_result,
    output logic [DATA_W-1:0] out_data
);
    assign out_data = in_mem_to_reg ? in_mem_data : in_alu_result;
endmodule

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB register and register-file writeback; WB_BYPASS_EN adds forwarding outputs
module mem_wb_writeback
    import mips8_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              wb_stall,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    output logic [CNT_W-1:0]  retired_cnt
`ifdef WB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [ADDR_W-1:0] byp_dest,
    output logic [DATA_W-1:0] byp_data
`endif
);
    wb_state_e         r_state;
    wb_entry_t         r_entry;
    logic [CNT_W-1:0]  r_retired_cnt;
    logic [DATA_W-1:0] w_mux_data;
    logic              w_accept;
    logic              w_commit;
    logic              w_writes_reg;

    wb_result_mux u_result_mux (
        .in_mem_to_reg (in_mem_to_reg),
        .in_mem_data   (in_mem_data),
        .in_alu_result (in_alu_result),
        .out_data      (w_mux_data)
    );

    // A stall only blocks intake when an entry is actually waiting to commit.
    assign in_ready     = (r_state == WB_EMPTY) | ~wb_stall;
    assign w_accept     = in_valid & in_ready;
    assign w_commit     = (r_state == WB_FULL) & ~wb_stall;
    assign w_writes_reg = r_entry.en & (r_entry.dest != REG_ZERO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= WB_EMPTY;
            r_entry       <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (w_commit) begin
                r_retired_cnt <= r_retired_cnt + 1'b1;
            end
            if (w_accept) begin
                r_state <= WB_FULL;
                r_entry <= '{en: in_reg_write, dest: in_dest, data: w_mux_data};
            end else if (w_commit) begin
                r_state <= WB_EMPTY;
            end
        end
    end

    assign reg_write_en   = w_commit & w_writes_reg;
    assign reg_write_dest = w_commit ? r_entry.dest : '0;
    assign reg_write_data = w_commit ? r_entry.data : '0;
    assign retired_cnt    = r_retired_cnt;

`ifdef WB_BYPASS_EN
    // Forwarding sees the held entry even while the commit is stalled.
    assign byp_valid = (r_state == WB_FULL) & w_writes_reg;
    assign byp_dest  = byp_valid ? r_entry.dest : '0;
    assign byp_data  = byp_valid ? r_entry.data : '0;
`endif
endmodule
